// File: rtl/div_share_ctrl.sv
// div_share_ctrl: shares one fixed-latency pipelined divider among NREQ
// requesters with credit-based issue and a response FIFO.
// Ports: clk, rst (async, active-high); req_valid/req_ready plus packed
// req_dividend/req_divisor per requester; div_dividend/div_divisor to the
// divider, div_quotient/div_remainder back; rsp_valid/rsp_ready with
// rsp_id, rsp_quotient, rsp_remainder, rsp_dz; busy.
// Build option DIV_FIXED_PRIO_EN: lowest-index requester always wins
// (default build is round-robin).
module div_share_ctrl #(
  parameter int N     = 6,
  parameter int M     = 4,
  parameter int NREQ  = 4,
  parameter int LAT   = 5,
  parameter int DEPTH = 8,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*N-1:0]   req_dividend,
  input  logic [NREQ*M-1:0]   req_divisor,
  output logic [N-1:0]        div_dividend,
  output logic [M-1:0]        div_divisor,
  input  logic [N-1:0]        div_quotient,
  input  logic [M-1:0]        div_remainder,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [N-1:0]        rsp_quotient,
  output logic [M-1:0]        rsp_remainder,
  output logic                rsp_dz,
  output logic                busy
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int EW = IDW + 1 + N + M;

  logic [CW-1:0]  inflight;
  logic [CW-1:0]  fcnt;
  logic [PW-1:0]  wp;
  logic [PW-1:0]  rp;
  logic [EW-1:0]  mem [DEPTH];

  logic [LAT:0]   tv;
  logic [LAT:0]   tdz;
  logic [IDW-1:0] tid [LAT+1];

  logic           credit;
  logic           found;
  logic [IDW-1:0] sel;
  logic           xfer;
  logic [N-1:0]   sdvd;
  logic [M-1:0]   sdvs;
  logic           sdz;
  logic           wr;
  logic           pop;
  logic [N-1:0]   wq;
  logic [M-1:0]   wrm;

  // Registered counts only: a slot freed by a pop is reusable next cycle.
  assign credit = ({1'b0, inflight} + {1'b0, fcnt})
                < (CW+1)'(DEPTH);

`ifdef DIV_FIXED_PRIO_EN
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        found = 1'b1;
        sel   = IDW'(i);
      end
    end
  end
`else
  logic [IDW-1:0] last;
  logic [IDW-1:0] idx;
  int             ci;

  // Search starts one past the last winner and wraps.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    ci    = 0;
    for (int k = 1; k <= NREQ; k++) begin
      ci = int'(last) + k;
      if (ci >= NREQ) ci = ci - NREQ;
      idx = IDW'(ci);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last <= IDW'(NREQ - 1);
    else if (xfer) last <= sel;
  end
`endif

  always_comb begin
    req_ready = '0;
    if (found && credit && !rst) req_ready[sel] = 1'b1;
  end

  assign xfer = |(req_valid & req_ready);

  always_comb begin
    sdvd = '0;
    sdvs = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (sel == IDW'(i)) begin
        sdvd = req_dividend[i*N +: N];
        sdvs = req_divisor[i*M +: M];
      end
    end
  end

  assign sdz = (sdvs == '0);

  // A zero divisor is replaced by 1 so the divider never sees it;
  // the dz tag fixes up the result on the way out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_dividend <= '0;
      div_divisor  <= M'(1);
    end else if (xfer) begin
      div_dividend <= sdvd;
      div_divisor  <= sdz ? M'(1) : sdvs;
    end
  end

  // Stage LAT lines up with the divider outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tv  <= '0;
      tdz <= '0;
      for (int k = 0; k <= LAT; k++) tid[k] <= '0;
    end else begin
      tv     <= {tv[LAT-1:0], xfer};
      tdz    <= {tdz[LAT-1:0], sdz};
      tid[0] <= sel;
      for (int k = 1; k <= LAT; k++) tid[k] <= tid[k-1];
    end
  end

  assign wr  = tv[LAT];
  assign wq  = tdz[LAT] ? {N{1'b1}} : div_quotient;
  assign wrm = tdz[LAT] ? '0 : div_remainder;

  assign rsp_valid = (fcnt != '0);
  assign pop       = rsp_valid & rsp_ready;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else begin
      if (wr) begin
        mem[wp] <= {tid[LAT], tdz[LAT], wq, wrm};
        wp      <= nxt(wp);
      end
      if (pop) rp <= nxt(rp);
    end
  end

  assign {rsp_id, rsp_dz, rsp_quotient, rsp_remainder} = mem[rp];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({xfer, wr})
        2'b10:   inflight <= inflight + CW'(1);
        2'b01:   inflight <= inflight - CW'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt <= '0;
    end else begin
      case ({wr, pop})
        2'b10:   fcnt <= fcnt + CW'(1);
        2'b01:   fcnt <= fcnt - CW'(1);
        default: fcnt <= fcnt;
      endcase
    end
  end

  assign busy = (inflight != '0) | (fcnt != '0);

endmodule

// File: tb/tb_div_share_ctrl.sv
// tb_div_share_ctrl: directed bench for div_share_ctrl with a behavioural
// LAT-cycle divider and an in-order response scoreboard.
module tb_div_share_ctrl;

  localparam int N    = 6;
  localparam int M    = 4;
  localparam int NREQ = 4;
  localparam int LAT  = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_dividend;
  logic [NREQ*M-1:0] req_divisor;
  logic [N-1:0]      div_dividend;
  logic [M-1:0]      div_divisor;
  logic [N-1:0]      div_quotient;
  logic [M-1:0]      div_remainder;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [N-1:0]      rsp_quotient;
  logic [M-1:0]      rsp_remainder;
  logic              rsp_dz;
  logic              busy;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [1:0]   id;
    logic         dz;
    logic [N-1:0] q;
    logic [M-1:0] r;
  } exp_t;

  exp_t sb[$];

  div_share_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_remainder(div_remainder),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_quotient(rsp_quotient),
    .rsp_remainder(rsp_remainder), .rsp_dz(rsp_dz),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Divider model: result of the operands seen in a cycle appears
  // LAT cycles later.
  logic [N-1:0] pq [LAT];
  logic [M-1:0] pr [LAT];

  always @(posedge clk) begin
    if (div_divisor == '0) begin
      pq[0] <= '0;
      pr[0] <= '0;
    end else begin
      pq[0] <= div_dividend / div_divisor;
      pr[0] <= M'(div_dividend % div_divisor);
    end
    for (int k = 1; k < LAT; k++) begin
      pq[k] <= pq[k-1];
      pr[k] <= pr[k-1];
    end
  end

  assign div_quotient  = pq[LAT-1];
  assign div_remainder = pr[LAT-1];

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input int a, input int b);
    req_dividend[i*N +: N] = N'(a);
    req_divisor[i*M +: M]  = M'(b);
  endtask

  task automatic wait_idle(input int max);
    for (int c = 0; c < max && (busy || sb.size() != 0); c++)
      @(negedge clk);
    check("idle_busy", busy, 0);
    check("idle_sb", sb.size(), 0);
  endtask

  // Scoreboard: push on every transfer, pop on every response.
  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      check("ready_onehot", $countones(req_ready) <= 1, 1);
      if (rsp_valid && rsp_ready) begin
        check("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("rsp_id", rsp_id, e.id);
          check("rsp_dz", rsp_dz, e.dz);
          check("rsp_q", rsp_quotient, e.q);
          check("rsp_r", rsp_remainder, e.r);
        end
      end
      for (int i = 0; i < NREQ; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_t e;
          logic [N-1:0] a;
          logic [M-1:0] b;
          a = req_dividend[i*N +: N];
          b = req_divisor[i*M +: M];
          e.id = 2'(i);
          e.dz = (b == '0);
          if (b == '0) begin
            e.q = '1;
            e.r = '0;
          end else begin
            e.q = a / b;
            e.r = M'(a % b);
          end
          sb.push_back(e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  exp_g;
    int          nx;
    logic [12:0] snap;

    rst = 1'b1;
    req_valid = '0;
    req_dividend = '0;
    req_divisor = '0;
    rsp_ready = 1'b0;

    @(negedge clk);
    check("rst_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_dz", rsp_dz, 0);
    check("rst_dvd", div_dividend, 0);
    check("rst_dvs", div_divisor, 1);
    @(posedge clk); #1 rst = 1'b0;

    // Fairness
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 40 + i * 5, i + 3);
    req_valid = 4'hf;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
`ifdef DIV_FIXED_PRIO_EN
      exp_g = 4'b0001;
`else
      exp_g = 4'b0001 << (k % 4);
`endif
      check("fair_grant", req_ready, exp_g);
    end
    @(posedge clk); #1 req_valid = '0;
    wait_idle(40);

    // Single operation latency
    @(posedge clk); #1;
    set_req(0, 45, 7);
    req_valid = 4'b0001;
    @(negedge clk);
    check("single_grant", req_ready, 4'b0001);
    @(posedge clk); #1 req_valid = '0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("single_lat", rsp_valid, 0);
    end
    @(negedge clk);
    check("single_valid", rsp_valid, 1);
    check("single_id", rsp_id, 0);
    check("single_q", rsp_quotient, 6);
    check("single_r", rsp_remainder, 3);
    check("single_dz", rsp_dz, 0);
    check("single_busy", busy, 1);
    @(posedge clk); #1;
    @(negedge clk);
    check("single_busy_end", busy, 0);
    check("single_valid_end", rsp_valid, 0);

    // Backpressure
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, 60 - i * 3, 9 - i);
    req_valid = 4'hf;
    nx = 0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (|req_ready) nx++;
    end
    check("bp_xfers", nx, 8);
    check("bp_ready", req_ready, 0);
    check("bp_valid", rsp_valid, 1);
    snap = {rsp_id, rsp_dz, rsp_quotient, rsp_remainder};
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_stable",
            {rsp_id, rsp_dz, rsp_quotient, rsp_remainder}, snap);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_pop_valid", rsp_valid, 1);
    @(negedge clk);
    check("bp_resume", |req_ready, 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("bp_drain_valid", rsp_valid, 1);
    end
    @(posedge clk); #1 req_valid = '0;
    wait_idle(60);

    // Divide by zero
    @(posedge clk); #1;
    set_req(2, 13, 0);
    req_valid = 4'b0100;
    @(negedge clk);
    check("dz_grant", req_ready, 4'b0100);
    @(posedge clk); #1 req_valid = '0;
    @(negedge clk);
    check("dz_div_dvs", div_divisor, 1);
    check("dz_div_dvd", div_dividend, 13);
    for (int c = 0; c < 20 && !rsp_valid; c++) @(negedge clk);
    check("dz_valid", rsp_valid, 1);
    check("dz_id", rsp_id, 2);
    check("dz_flag", rsp_dz, 1);
    check("dz_q", rsp_quotient, 63);
    check("dz_r", rsp_remainder, 0);
    wait_idle(20);

    // Reset with operations in flight
    @(posedge clk); #1;
    set_req(0, 20, 3);
    set_req(1, 33, 4);
    set_req(3, 50, 6);
    req_valid = 4'b1011;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_ready", req_ready, 0);
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_dz", rsp_dz, 0);
    check("mid_rst_dvd", div_dividend, 0);
    check("mid_rst_dvs", div_divisor, 1);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    req_valid = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("post_rst_valid", rsp_valid, 0);
      check("post_rst_busy", busy, 0);
    end

    // Arbitration mode
    @(posedge clk); #1;
    set_req(0, 30, 4);
    set_req(2, 31, 5);
    req_valid = 4'b0101;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
`ifdef DIV_FIXED_PRIO_EN
      exp_g = 4'b0001;
`else
      exp_g = (k % 2 == 0) ? 4'b0001 : 4'b0100;
`endif
      check("prio_grant", req_ready, exp_g);
    end
    @(posedge clk); #1 req_valid = '0;
    wait_idle(30);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
